// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader and its downstream comparer.
// Optional feature macro: SWL_PARITY_EN (adds a trailing even-parity bit).
package serial_word_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } swl_state_e;

  // Word width, shared with the equality comparer downstream.
  localparam int SWL_WIDTH_DEFAULT   = 16;
  localparam int SWL_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/serial_word_loader_gap_timer.sv
// Saturating inter-bit gap counter. reached pulses on the idle cycle whose
// count would land on TIMEOUT, so the FSM can abort on that same edge.
module swl_gap_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic reached
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT    = TW'(TIMEOUT);
  localparam logic [TW-1:0] LIMIT_M1 = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: clear wins, otherwise count idle cycles up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign reached = en && !clr && (cnt_q == LIMIT_M1);

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader, MSB first, with start/valid handshake,
// inter-bit timeout and a one-cycle completion strobe.
// Optional feature macro: SWL_PARITY_EN (one extra even-parity bit per frame).
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int N       = SWL_WIDTH_DEFAULT,
  parameter int TIMEOUT = SWL_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  swl_state_e    state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  word_q, word_d;
  logic          word_valid_q, word_valid_d;
  logic          err_q, err_d;
  logic          gap_clr;
  logic          gap_en;
  logic          gap_reached;

  swl_gap_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (gap_clr),
    .en      (gap_en),
    .reached (gap_reached)
  );

  // Frame sequencing: next state, shift data, strobes and timer control.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    err_d        = 1'b0;
    gap_clr      = 1'b0;
    gap_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        gap_clr = 1'b1;
        // A bit_valid coincident with start is deliberately dropped.
        if (start) begin
          state_d = ST_SHIFT;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end

      ST_SHIFT: begin
        if (bit_valid) begin
          gap_clr = 1'b1;
          sreg_d  = {sreg_q[N-2:0], bit_in};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef SWL_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_DONE;
`endif
          end
        end else begin
          gap_en = 1'b1;
          if (gap_reached) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end

`ifdef SWL_PARITY_EN
      ST_PARITY: begin
        if (bit_valid) begin
          gap_clr = 1'b1;
          if (^{sreg_q, bit_in} == 1'b0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else begin
          gap_en = 1'b1;
          if (gap_reached) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif

      ST_DONE: begin
        gap_clr      = 1'b1;
        word_d       = sreg_q;
        word_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end

      default: begin
        gap_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      err_q        <= err_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader (N=16, TIMEOUT=8).
// Optional feature macro: SWL_PARITY_EN (bench appends parity bits and adds parity cases).
module tb_serial_word_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  serial_word_loader #(
    .N       (16),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  // Sends the data bits (and parity bit when enabled), then checks the strobe
  // lands one DONE cycle after the final accepted bit.
  task automatic frame_body(input logic [15:0] w, input int gap, input int start_at);
    for (int i = 15; i >= 0; i--) begin
      bit_in    = w[i];
      bit_valid = 1'b1;
      start     = ((15 - i) == start_at);
      tick();
      start     = 1'b0;
      bit_valid = 1'b0;
      if (i != 0) repeat (gap) tick();
    end
`ifdef SWL_PARITY_EN
    bit_in    = ^w;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
`endif
    chk1("wv_early", word_valid, 1'b0);
    chk1("busy_done", busy, 1'b1);
    tick();
    chk1("wv_pulse", word_valid, 1'b1);
    chk16("word", word_out, w);
    chk1("cmp_y", (word_out === 16'hBEEF) && word_valid, (w == 16'hBEEF));
    chk1("err_quiet", err, 1'b0);
    tick();
    chk1("wv_drop", word_valid, 1'b0);
    chk1("busy_after", busy, 1'b0);
  endtask

  task automatic do_frame(input logic [15:0] w, input int gap, input int start_at);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("busy_start", busy, 1'b1);
    frame_body(w, gap, start_at);
  endtask

  initial begin
    logic [15:0] pat;

    // Reset state
    #2;
    chk16("rst_word", word_out, 16'h0000);
    chk1("rst_wv", word_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Basic continuous frame
    do_frame(16'hA5C3, 0, -1);

    // Gapped bits, gap below timeout
    do_frame(16'h0001, 3, -1);

    // Timeout: stall 8 cycles after bit 5
    start = 1'b1;
    tick();
    start = 1'b0;
    pat = 16'hF000;
    for (int i = 15; i >= 11; i--) begin
      bit_in    = pat[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
    repeat (7) tick();
    chk1("to_err_early", err, 1'b0);
    chk1("to_busy_early", busy, 1'b1);
    tick();
    chk1("to_err", err, 1'b1);
    chk1("to_busy", busy, 1'b0);
    chk1("to_wv", word_valid, 1'b0);
    chk16("to_word_kept", word_out, 16'h0001);
    tick();
    chk1("to_err_drop", err, 1'b0);

    // Start coincident with bit_valid: that bit must be dropped
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk1("coll_busy", busy, 1'b1);
    frame_body(16'hFFFF, 0, -1);

    // Start asserted along with bit 7 is ignored
    do_frame(16'h5A5A, 0, 6);

    // Reset mid-frame after 9 bits
    start = 1'b1;
    tick();
    start = 1'b0;
    pat = 16'h1234;
    for (int i = 15; i >= 7; i--) begin
      bit_in    = pat[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
    rst = 1'b1;
    #2;
    chk16("mrst_word", word_out, 16'h0000);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_wv", word_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk1("mrst_wv_after", word_valid, 1'b0);
    do_frame(16'h1234, 0, -1);

    // Back-to-back frames, start one cycle after the first strobe
    do_frame(16'hDEAD, 0, -1);
    do_frame(16'hBEEF, 0, -1);

`ifdef SWL_PARITY_EN
    // Bad parity: err pulse, no strobe, word kept
    start = 1'b1;
    tick();
    start = 1'b0;
    pat = 16'hA5C3;
    for (int i = 15; i >= 0; i--) begin
      bit_in    = pat[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
    end
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk1("par_err", err, 1'b1);
    chk1("par_wv", word_valid, 1'b0);
    chk1("par_busy", busy, 1'b0);
    chk16("par_word_kept", word_out, 16'hBEEF);
    tick();
    chk1("par_err_drop", err, 1'b0);
    chk1("par_wv_after", word_valid, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
